lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 47 ++++
 rtl/lsu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Request/response/bus bundle for lsu_ctrl.
// master: the load/store unit side (drives bus request and response).
// slave:  the environment side (pipeline front end, memory and consumer).
interface lsu_ctrl_if;
    // Decoded memory request from the pipeline
    logic        req_valid;
    logic        req_ready;
    logic        MemWr;
    logic [2:0]  MemOP;
    logic [63:0] addr;
    logic [63:0] wdata;

    // Response to the pipeline
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    // Memory bus (one request outstanding)
    logic        mem_valid;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_rerr;

    modport master (
        input  req_valid, MemWr, MemOP, addr, wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata, mem_rerr
    );

    modport slave (
        output req_valid, MemWr, MemOP, addr, wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata, mem_rerr
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one decoded memory request at a time,
// issues it on a 64-bit word bus with byte lanes, and returns extended load
// data (or store completion) to the pipeline.
// Optional feature: define LSU_MISALIGN_CHECK_EN to fault accesses that are
// not naturally aligned to their size without touching the bus. Without it,
// misaligned accesses go to the bus and bytes past the word are dropped.
module lsu_ctrl (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} stateT;

    stateT       stateReg;
    logic        isWrReg;
    logic [2:0]  opReg;
    logic [2:0]  offReg;

    logic        reqReadyReg;
    logic        memValidReg;
    logic        memWeReg;
    logic [63:0] memAddrReg;
    logic [63:0] memWdataReg;
    logic [7:0]  memWmaskReg;
    logic        rspValidReg;
    logic [63:0] rspRdataReg;
    logic        rspErrReg;

    logic [2:0]  inOff;
    logic [3:0]  inBytes;
    logic [7:0]  laneMask;
    logic [63:0] wdataShifted;

    assign inOff        = bus.addr[2:0];
    assign wdataShifted = bus.wdata << {inOff, 3'b000};

    // Access size in bytes from the func3 size field
    always_comb begin
        inBytes = 4'd1;
        case (bus.MemOP[1:0])
            2'b00:   inBytes = 4'd1;
            2'b01:   inBytes = 4'd2;
            2'b10:   inBytes = 4'd4;
            default: inBytes = 4'd8;
        endcase
    end

    // Byte lane gi is written when it falls inside [off, off+size); lanes past 7 simply vanish
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : gLane
            assign laneMask[gi] = (4'(gi) >= {1'b0, inOff}) &&
                                  (4'(gi) <  ({1'b0, inOff} + inBytes));
        end
    endgenerate

`ifdef LSU_MISALIGN_CHECK_EN
    logic [2:0] alignMask;
    logic       misaligned;
    assign alignMask  = 3'(inBytes - 4'd1);
    assign misaligned = |(inOff & alignMask);
`endif

    // Right-align the addressed bytes, keep the access size, then sign/zero extend
    function automatic logic [63:0] extendLoad(input logic [63:0] raw,
                                               input logic [2:0]  op,
                                               input logic [2:0]  off);
        logic [63:0] sh;
        logic [63:0] res;
        sh = raw >> {off, 3'b000};
        case (op[1:0])
            2'b00:   res = op[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'b01:   res = op[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'b10:   res = op[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign bus.req_ready = reqReadyReg;
    assign bus.mem_valid = memValidReg;
    assign bus.mem_we    = memWeReg;
    assign bus.mem_addr  = memAddrReg;
    assign bus.mem_wdata = memWdataReg;
    assign bus.mem_wmask = memWmaskReg;
    assign bus.rsp_valid = rspValidReg;
    assign bus.rsp_rdata = rspRdataReg;
    assign bus.rsp_err   = rspErrReg;

    // Transaction FSM with registered outputs; request inputs only matter in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            isWrReg     <= 1'b0;
            opReg       <= 3'b000;
            offReg      <= 3'b000;
            reqReadyReg <= 1'b1;
            memValidReg <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            memWmaskReg <= '0;
            rspValidReg <= 1'b0;
            rspRdataReg <= '0;
            rspErrReg   <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (bus.req_valid) begin
                        reqReadyReg <= 1'b0;
                        isWrReg     <= bus.MemWr;
                        opReg       <= bus.MemOP;
                        offReg      <= inOff;
                        if (bus.MemOP == 3'b111) begin
                            // No-op completes immediately with a clean response
                            stateReg    <= RESP;
                            rspValidReg <= 1'b1;
                            rspRdataReg <= '0;
                            rspErrReg   <= 1'b0;
                        end
`ifdef LSU_MISALIGN_CHECK_EN
                        else if (misaligned) begin
                            // Misaligned access faults without a bus cycle
                            stateReg    <= RESP;
                            rspValidReg <= 1'b1;
                            rspRdataReg <= '0;
                            rspErrReg   <= 1'b1;
                        end
`endif
                        else begin
                            stateReg    <= REQ;
                            memValidReg <= 1'b1;
                            memWeReg    <= bus.MemWr;
                            memAddrReg  <= {bus.addr[63:3], 3'b000};
                            memWdataReg <= wdataShifted;
                            memWmaskReg <= bus.MemWr ? laneMask : 8'h00;
                        end
                    end
                end
                REQ: begin
                    // Any mem_rvalid here belongs to nothing we issued
                    if (bus.mem_ready) begin
                        stateReg    <= WAIT;
                        memValidReg <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        stateReg    <= RESP;
                        rspValidReg <= 1'b1;
                        rspErrReg   <= bus.mem_rerr;
                        rspRdataReg <= isWrReg ? 64'd0
                                               : extendLoad(bus.mem_rdata, opReg, offReg);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        stateReg    <= IDLE;
                        rspValidReg <= 1'b0;
                        reqReadyReg <= 1'b1;
                    end
                end
                default: begin
                    stateReg    <= IDLE;
                    reqReadyReg <= 1'b1;
                    memValidReg <= 1'b0;
                    rspValidReg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed spot cases plus randomized
// transactions with random bus/consumer stalls and junk inputs while busy.
// A per-cycle compare process checks every output against expectations
// derived from transaction-level arithmetic.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_ctrl_if lsuBus();

    lsu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (lsuBus)
    );

    int errors = 0;
    int checks = 0;
    int txnCount = 0;

    logic        checkEn = 1'b0;
    logic        expReqReady = 1'b1;
    logic        expMemValid = 1'b0;
    logic        expMemWe = 1'b0;
    logic [63:0] expMemAddr = '0;
    logic [63:0] expMemWdata = '0;
    logic [7:0]  expMemWmask = '0;
    logic        expRspValid = 1'b0;
    logic [63:0] expRspRdata = '0;
    logic        expRspErr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model ----
    function automatic logic [7:0] mWmask(input logic wr, input logic [2:0] op, input logic [63:0] a);
        int n;
        logic [15:0] t;
        if (!wr) return 8'h00;
        n = 1 << op[1:0];
        t = 16'((1 << n) - 1) << a[2:0];
        return t[7:0];
    endfunction

    function automatic logic [63:0] mLoad(input logic [2:0] op, input logic [63:0] a, input logic [63:0] rd);
        int n;
        int off;
        logic [63:0] v;
        n   = 1 << op[1:0];
        off = int'(a[2:0]);
        v   = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!op[2] && n < 8 && v[8*n-1])
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit mIsBus(input logic [2:0] op, input logic [63:0] a);
        if (op == 3'b111) return 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((int'(a[2:0]) % (1 << op[1:0])) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // ---- per-cycle compare ----
    always @(negedge clk) begin
        if (checkEn) begin
            chk("req_ready", {63'd0, lsuBus.req_ready}, {63'd0, expReqReady});
            chk("mem_valid", {63'd0, lsuBus.mem_valid}, {63'd0, expMemValid});
            if (expMemValid) begin
                chk("mem_we",    {63'd0, lsuBus.mem_we}, {63'd0, expMemWe});
                chk("mem_addr",  lsuBus.mem_addr, expMemAddr);
                chk("mem_wdata", lsuBus.mem_wdata, expMemWdata);
                chk("mem_wmask", {56'd0, lsuBus.mem_wmask}, {56'd0, expMemWmask});
            end
            chk("rsp_valid", {63'd0, lsuBus.rsp_valid}, {63'd0, expRspValid});
            if (expRspValid) begin
                chk("rsp_rdata", lsuBus.rsp_rdata, expRspRdata);
                chk("rsp_err",   {63'd0, lsuBus.rsp_err}, {63'd0, expRspErr});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Garbage on the request inputs while the unit is busy
    task automatic junk();
        lsuBus.req_valid = 1'($urandom % 2);
        lsuBus.MemWr     = 1'($urandom % 2);
        lsuBus.MemOP     = 3'($urandom % 8);
        lsuBus.addr      = {$urandom, $urandom};
        lsuBus.wdata     = {$urandom, $urandom};
    endtask

    task automatic doTxn(input logic wr, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input logic re,
                         input int dReady, input int dRv, input int dRsp, input logic earlyRv);
        bit onBus;
        onBus = mIsBus(op, a);
        lsuBus.req_valid = 1'b1;
        lsuBus.MemWr     = wr;
        lsuBus.MemOP     = op;
        lsuBus.addr      = a;
        lsuBus.wdata     = wd;
        tick();
        expReqReady = 1'b0;
        junk();
        if (onBus) begin
            expMemValid = 1'b1;
            expMemWe    = wr;
            expMemAddr  = {a[63:3], 3'b000};
            expMemWdata = wd << (8 * a[2:0]);
            expMemWmask = mWmask(wr, op, a);
            for (int i = 0; i < dReady; i++) begin
                tick();
                junk();
            end
            lsuBus.mem_ready = 1'b1;
            if (earlyRv) begin
                lsuBus.mem_rvalid = 1'b1;
                lsuBus.mem_rdata  = {$urandom, $urandom};
                lsuBus.mem_rerr   = ~re;
            end
            tick();
            lsuBus.mem_ready  = 1'b0;
            lsuBus.mem_rvalid = 1'b0;
            expMemValid = 1'b0;
            junk();
            for (int i = 0; i < dRv; i++) begin
                tick();
                junk();
            end
            lsuBus.mem_rvalid = 1'b1;
            lsuBus.mem_rdata  = rd;
            lsuBus.mem_rerr   = re;
            tick();
            lsuBus.mem_rvalid = 1'b0;
            lsuBus.mem_rerr   = 1'b0;
            lsuBus.mem_rdata  = {$urandom, $urandom};
            junk();
            expRspRdata = wr ? 64'd0 : mLoad(op, a, rd);
            expRspErr   = re;
        end else begin
            expRspRdata = 64'd0;
            expRspErr   = (op != 3'b111);
        end
        expRspValid = 1'b1;
        for (int i = 0; i < dRsp; i++) begin
            tick();
            junk();
        end
        lsuBus.rsp_ready = 1'b1;
        tick();
        lsuBus.rsp_ready = 1'b0;
        lsuBus.req_valid = 1'b0;
        expRspValid = 1'b0;
        expReqReady = 1'b1;
        txnCount++;
        $display("txn %0d wr=%0b op=%0d addr=%h wdata=%h bus=%0b exp_rdata=%h exp_err=%0b",
                 txnCount, wr, op, a, wd, onBus, expRspRdata, expRspErr);
    endtask

    initial begin
        logic        wr;
        logic [2:0]  op;
        logic [63:0] a;
        logic        re;
        int          dReady, dRv, dRsp;

        lsuBus.req_valid  = 1'b0;
        lsuBus.MemWr      = 1'b0;
        lsuBus.MemOP      = 3'b000;
        lsuBus.addr       = '0;
        lsuBus.wdata      = '0;
        lsuBus.rsp_ready  = 1'b0;
        lsuBus.mem_ready  = 1'b0;
        lsuBus.mem_rvalid = 1'b0;
        lsuBus.mem_rdata  = '0;
        lsuBus.mem_rerr   = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", {63'd0, lsuBus.req_ready}, 64'd1);
        chk("rst_mem_valid", {63'd0, lsuBus.mem_valid}, 64'd0);
        chk("rst_mem_we",    {63'd0, lsuBus.mem_we}, 64'd0);
        chk("rst_mem_addr",  lsuBus.mem_addr, 64'd0);
        chk("rst_mem_wdata", lsuBus.mem_wdata, 64'd0);
        chk("rst_mem_wmask", {56'd0, lsuBus.mem_wmask}, 64'd0);
        chk("rst_rsp_valid", {63'd0, lsuBus.rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", lsuBus.rsp_rdata, 64'd0);
        chk("rst_rsp_err",   {63'd0, lsuBus.rsp_err}, 64'd0);
        rst = 1'b0;
        checkEn = 1'b1;

        // Hand-computed values pinning the model
        chk("pin_lb_rdata",  mLoad(3'b000, 64'h80000003, 64'h00000000_F0000000), 64'hFFFFFFFF_FFFFFFF0);
        chk("pin_lb_wmask",  {56'd0, mWmask(1'b0, 3'b000, 64'h80000003)}, 64'h00);
        chk("pin_sh_wmask",  {56'd0, mWmask(1'b1, 3'b001, 64'h80000006)}, 64'hC0);
        chk("pin_sh_wdata",  64'h1234 << (8 * 6), 64'h12340000_00000000);
        chk("pin_lwu_rdata", mLoad(3'b110, 64'h80000004, 64'h80000001_DEADBEEF), 64'h00000000_80000001);
        chk("pin_lw_mis",    mLoad(3'b010, 64'h80000002, 64'h11223344_55667788), 64'h00000000_33445566);

        // Directed cases
        doTxn(1'b0, 3'b000, 64'h80000003, 64'd0, 64'h00000000_F0000000, 1'b0, 0, 0, 0, 1'b0);
        doTxn(1'b1, 3'b001, 64'h80000006, 64'h1234, 64'hA5A5A5A5_A5A5A5A5, 1'b0, 0, 0, 0, 1'b0);
        doTxn(1'b0, 3'b110, 64'h80000004, 64'd0, 64'h80000001_DEADBEEF, 1'b0, 0, 0, 0, 1'b0);
        doTxn(1'b0, 3'b010, 64'h80000000, 64'd0, 64'h01234567_89ABCDEF, 1'b0, 5, 0, 3, 1'b0);
        doTxn(1'b0, 3'b010, 64'h80000002, 64'd0, 64'h11223344_55667788, 1'b0, 0, 0, 0, 1'b0);
        doTxn(1'b1, 3'b011, 64'h80000008, 64'hCAFEF00D_12345678, 64'd0, 1'b1, 1, 2, 1, 1'b0);
        doTxn(1'b0, 3'b111, 64'h80000001, 64'd0, 64'd0, 1'b0, 0, 0, 2, 1'b0);
        doTxn(1'b0, 3'b011, 64'h80000010, 64'd0, 64'hFEDCBA98_76543210, 1'b0, 0, 0, 0, 1'b1);

        // Reset while waiting for the bus response; the late response must vanish
        lsuBus.req_valid = 1'b1;
        lsuBus.MemWr     = 1'b0;
        lsuBus.MemOP     = 3'b011;
        lsuBus.addr      = 64'h80000020;
        lsuBus.wdata     = 64'd0;
        tick();
        lsuBus.req_valid = 1'b0;
        expReqReady = 1'b0;
        expMemValid = 1'b1;
        expMemWe    = 1'b0;
        expMemAddr  = 64'h80000020;
        expMemWdata = 64'd0;
        expMemWmask = 8'h00;
        lsuBus.mem_ready = 1'b1;
        tick();
        lsuBus.mem_ready = 1'b0;
        expMemValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expReqReady = 1'b1;
        chk("rstmid_mem_addr",  lsuBus.mem_addr, 64'd0);
        chk("rstmid_rsp_rdata", lsuBus.rsp_rdata, 64'd0);
        lsuBus.mem_rvalid = 1'b1;
        lsuBus.mem_rdata  = 64'hDEADBEEF_DEADBEEF;
        tick();
        lsuBus.mem_rvalid = 1'b0;
        repeat (3) tick();
        $display("txn reset-in-wait: late response dropped expected");

        // Randomized transactions
        for (int t = 0; t < 300; t++) begin
            wr = 1'($urandom % 2);
            if ($urandom % 8 == 0)
                op = 3'b111;
            else if (wr)
                op = 3'($urandom % 4);
            else
                op = 3'($urandom % 7);
            a = {$urandom, $urandom};
            if ($urandom % 2 == 0) a[2:0] = 3'b000;
            re     = 1'($urandom % 8 == 0);
            dReady = ($urandom % 3 == 0) ? int'($urandom % 4) : 0;
            dRv    = ($urandom % 3 == 0) ? int'($urandom % 4) : 0;
            dRsp   = ($urandom % 3 == 0) ? int'($urandom % 4) : 0;
            repeat ($urandom % 2) tick();
            doTxn(wr, op, a, {$urandom, $urandom}, {$urandom, $urandom}, re,
                  dReady, dRv, dRsp, 1'($urandom % 4 == 0));
        end

        repeat (2) tick();
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
